// File: rtl/spi_cmd_arbiter_if.sv
// Bundle of requester, SPI-master and status signals around the SPI command arbiter.
// The arbiter connects through the slave modport; the environment drives through master.
interface spi_cmd_arbiter_if #(
    parameter int CMD_W = 48
);
    logic             spi_initdone_i;
    logic             spi_initreq_i;
    logic [CMD_W-1:0] spi_datainit_i;
    logic [7:0]       spi_statusreginit_i;
    logic             spi_microreq_i;
    logic [CMD_W-1:0] spi_datamicro_i;
    logic [7:0]       spi_statusregmicro_i;
    logic [2:0]       spi_flagreg_i;
    logic [7:0]       R1;
    logic [CMD_W-1:0] spi_data_o;
    logic [7:0]       spi_statusreg_o;
    logic             spi_start_o;
    logic             spi_initgnt_o;
    logic             spi_micrognt_o;
    logic             spi_initack_o;
    logic             spi_microack_o;
    logic [7:0]       spi_r1_o;
    logic             spi_err_o;
    logic             spi_timeout_o;
    logic             spi_busy_o;

    modport slave (
        input  spi_initdone_i, spi_initreq_i, spi_datainit_i, spi_statusreginit_i,
        input  spi_microreq_i, spi_datamicro_i, spi_statusregmicro_i, spi_flagreg_i, R1,
        output spi_data_o, spi_statusreg_o, spi_start_o, spi_initgnt_o, spi_micrognt_o,
        output spi_initack_o, spi_microack_o, spi_r1_o, spi_err_o, spi_timeout_o, spi_busy_o
    );

    modport master (
        output spi_initdone_i, spi_initreq_i, spi_datainit_i, spi_statusreginit_i,
        output spi_microreq_i, spi_datamicro_i, spi_statusregmicro_i, spi_flagreg_i, R1,
        input  spi_data_o, spi_statusreg_o, spi_start_o, spi_initgnt_o, spi_micrognt_o,
        input  spi_initack_o, spi_microack_o, spi_r1_o, spi_err_o, spi_timeout_o, spi_busy_o
    );
endinterface

// File: rtl/spi_cmd_arbiter.sv
// Shares one SPI command master between the SD init sequencer (priority) and the boot
// micro; issues the frame, waits for done/error/timeout and returns R1 with an ack.
module spi_cmd_arbiter #(
    parameter int CMD_W       = 48,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 10
) (
    input  logic              spi_clk_i,
    input  logic              spi_rst_i,
    spi_cmd_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CMD_W-1:0] data_q,    data_d;
    logic [7:0]       status_q,  status_d;
    logic             start_q,   start_d;
    logic             initgnt_q, initgnt_d;
    logic             microgt_q, microgt_d;
    logic             initack_q, initack_d;
    logic             microak_q, microak_d;
    logic [7:0]       r1_q,      r1_d;
    logic             err_q,     err_d;
    logic             tmo_q,     tmo_d;
    logic             busy_q,    busy_d;

    logic busy_flag_s;
    logic done_flag_s;
    logic error_flag_s;

    assign busy_flag_s  = bus.spi_flagreg_i[0];
    assign done_flag_s  = bus.spi_flagreg_i[1];
    assign error_flag_s = bus.spi_flagreg_i[2];

    // Next-state and next-output computation; ack/err/timeout/start default to a single pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        status_d  = status_q;
        start_d   = 1'b0;
        initgnt_d = initgnt_q;
        microgt_d = microgt_q;
        initack_d = 1'b0;
        microak_d = 1'b0;
        r1_d      = r1_q;
        err_d     = 1'b0;
        tmo_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.spi_initreq_i) begin
                    state_d   = ST_ISSUE;
                    data_d    = bus.spi_datainit_i;
                    status_d  = bus.spi_statusreginit_i;
                    start_d   = 1'b1;
                    initgnt_d = 1'b1;
                    microgt_d = 1'b0;
                    cnt_d     = {CNT_W{1'b0}};
                end else if (bus.spi_microreq_i && bus.spi_initdone_i) begin
                    state_d   = ST_ISSUE;
                    data_d    = bus.spi_datamicro_i;
                    status_d  = bus.spi_statusregmicro_i;
                    start_d   = 1'b1;
                    initgnt_d = 1'b0;
                    microgt_d = 1'b1;
                    cnt_d     = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = {CNT_W{1'b0}};
            end
            ST_WAIT: begin
                // Completion priority: done, then error, then timeout.
                if (done_flag_s || error_flag_s || (cnt_q == CNT_LAST)) begin
                    state_d   = ST_RELEASE;
                    initack_d = initgnt_q;
                    microak_d = microgt_q;
                    initgnt_d = 1'b0;
                    microgt_d = 1'b0;
                    if (done_flag_s) begin
                        r1_d = bus.R1;
                    end else if (error_flag_s) begin
                        r1_d  = bus.R1;
                        err_d = 1'b1;
                    end else begin
                        r1_d  = 8'hFF;
                        tmo_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                // Hold off until the master drops busy/done so a stale done cannot complete the next command.
                if (!busy_flag_s && !done_flag_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge spi_clk_i) begin
        if (spi_rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            data_q    <= {CMD_W{1'b0}};
            status_q  <= 8'h00;
            start_q   <= 1'b0;
            initgnt_q <= 1'b0;
            microgt_q <= 1'b0;
            initack_q <= 1'b0;
            microak_q <= 1'b0;
            r1_q      <= 8'h00;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            status_q  <= status_d;
            start_q   <= start_d;
            initgnt_q <= initgnt_d;
            microgt_q <= microgt_d;
            initack_q <= initack_d;
            microak_q <= microak_d;
            r1_q      <= r1_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.spi_data_o      = data_q;
    assign bus.spi_statusreg_o = status_q;
    assign bus.spi_start_o     = start_q;
    assign bus.spi_initgnt_o   = initgnt_q;
    assign bus.spi_micrognt_o  = microgt_q;
    assign bus.spi_initack_o   = initack_q;
    assign bus.spi_microack_o  = microak_q;
    assign bus.spi_r1_o        = r1_q;
    assign bus.spi_err_o       = err_q;
    assign bus.spi_timeout_o   = tmo_q;
    assign bus.spi_busy_o      = busy_q;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Scoreboard bench for spi_cmd_arbiter: stimulus queues expected grants/completions,
// a negedge monitor pops and compares whenever the arbiter starts or acks a command.
module tb_spi_cmd_arbiter;

    localparam int CMD_W = 48;

    typedef struct packed {
        logic             is_init;
        logic [CMD_W-1:0] data;
        logic [7:0]       st;
    } gnt_t;

    typedef struct packed {
        logic       is_init;
        logic [7:0] r1;
        logic       err;
        logic       tmo;
    } cmp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    gnt_t gq[$];
    cmp_t cq[$];
    logic prev_start = 1'b0;

    spi_cmd_arbiter_if #(.CMD_W(CMD_W)) bus ();

    spi_cmd_arbiter #(.CMD_W(CMD_W), .TIMEOUT_CYC(16), .CNT_W(4)) dut (
        .spi_clk_i (clk),
        .spi_rst_i (rst),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int limit, output int n);
        n = 0;
        while (!bus.spi_start_o && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},   64'(bus.spi_data_o), 64'd0);
        check({tag, "_status"}, 64'(bus.spi_statusreg_o), 64'd0);
        check({tag, "_ctl"},    64'({bus.spi_start_o, bus.spi_initgnt_o, bus.spi_micrognt_o,
                                     bus.spi_initack_o, bus.spi_microack_o, bus.spi_err_o,
                                     bus.spi_timeout_o, bus.spi_busy_o}), 64'd0);
        check({tag, "_r1"},     64'(bus.spi_r1_o), 64'd0);
    endtask

    // Monitor: compares every start against the grant queue and every ack against the completion queue.
    always @(negedge clk) begin
        if (bus.spi_start_o === 1'b1) begin
            check("start_expected", 64'(gq.size() != 0), 64'd1);
            check("start_width", 64'(prev_start), 64'd0);
            if (gq.size() != 0) begin
                gnt_t g;
                g = gq.pop_front();
                check("gnt_owner", 64'({bus.spi_initgnt_o, bus.spi_micrognt_o}),
                      64'({g.is_init, ~g.is_init}));
                check("gnt_data", 64'(bus.spi_data_o), 64'(g.data));
                check("gnt_status", 64'(bus.spi_statusreg_o), 64'(g.st));
            end
        end
        if (bus.spi_initack_o === 1'b1 || bus.spi_microack_o === 1'b1) begin
            check("ack_expected", 64'(cq.size() != 0), 64'd1);
            if (cq.size() != 0) begin
                cmp_t c;
                c = cq.pop_front();
                check("ack_owner", 64'({bus.spi_initack_o, bus.spi_microack_o}),
                      64'({c.is_init, ~c.is_init}));
                check("ack_r1", 64'(bus.spi_r1_o), 64'(c.r1));
                check("ack_err", 64'(bus.spi_err_o), 64'(c.err));
                check("ack_timeout", 64'(bus.spi_timeout_o), 64'(c.tmo));
                check("gnt_dropped", 64'({bus.spi_initgnt_o, bus.spi_micrognt_o}), 64'd0);
            end
        end else if (bus.spi_err_o === 1'b1 || bus.spi_timeout_o === 1'b1) begin
            check("status_without_ack", 64'd1, 64'd0);
        end
        prev_start = (bus.spi_start_o === 1'b1);
    end

    initial begin
        int n;
        bus.spi_initdone_i       = 1'b0;
        bus.spi_initreq_i        = 1'b0;
        bus.spi_datainit_i       = '0;
        bus.spi_statusreginit_i  = 8'h00;
        bus.spi_microreq_i       = 1'b0;
        bus.spi_datamicro_i      = '0;
        bus.spi_statusregmicro_i = 8'h00;
        bus.spi_flagreg_i        = 3'b000;
        bus.R1                   = 8'h00;

        tick(2);
        check_all_zero("reset");
        rst = 1'b0;

        // 1: init request, start is a single-cycle pulse one cycle later
        gq.push_back('{1'b1, 48'h400000000095, 8'hA5});
        bus.spi_initreq_i       = 1'b1;
        bus.spi_datainit_i      = 48'h400000000095;
        bus.spi_statusreginit_i = 8'hA5;
        tick(1);
        check("t1_start", 64'({bus.spi_start_o, bus.spi_initgnt_o}), 64'h3);
        tick(1);
        check("t1_start_low", 64'({bus.spi_start_o, bus.spi_busy_o}), 64'h1);

        // 2: done completes; held done keeps RELEASE until flags clear
        cq.push_back('{1'b1, 8'h01, 1'b0, 1'b0});
        bus.R1            = 8'h01;
        bus.spi_flagreg_i = 3'b010;
        tick(1);
        check("t2_ack", 64'(bus.spi_initack_o), 64'd1);
        bus.spi_initreq_i = 1'b0;
        tick(9);
        check("t2_release_hold", 64'({bus.spi_busy_o, bus.spi_initack_o}), 64'h2);
        bus.spi_flagreg_i = 3'b000;
        bus.R1            = 8'h00;
        tick(1);
        check("t2_idle", 64'(bus.spi_busy_o), 64'd0);
        check("t2_data_held", 64'(bus.spi_data_o), 64'h400000000095);

        // 3: micro locked out until initdone; then error completion
        bus.spi_microreq_i       = 1'b1;
        bus.spi_datamicro_i      = 48'h112233445566;
        bus.spi_statusregmicro_i = 8'h3C;
        tick(20);
        check("t3_locked", 64'({bus.spi_micrognt_o, bus.spi_busy_o}), 64'd0);
        gq.push_back('{1'b0, 48'h112233445566, 8'h3C});
        bus.spi_initdone_i = 1'b1;
        tick(1);
        check("t3_gnt", 64'(bus.spi_micrognt_o), 64'd1);
        tick(1);
        cq.push_back('{1'b0, 8'h05, 1'b1, 1'b0});
        bus.R1            = 8'h05;
        bus.spi_flagreg_i = 3'b100;
        tick(1);
        check("t3_ack", 64'(bus.spi_microack_o), 64'd1);
        bus.spi_microreq_i = 1'b0;
        bus.spi_flagreg_i  = 3'b000;
        tick(2);

        // 4: simultaneous requests, init first (done beats error), micro after one IDLE cycle
        gq.push_back('{1'b1, 48'h48000001AA87, 8'h11});
        gq.push_back('{1'b0, 48'h7A0000000001, 8'h22});
        bus.spi_datainit_i       = 48'h48000001AA87;
        bus.spi_statusreginit_i  = 8'h11;
        bus.spi_datamicro_i      = 48'h7A0000000001;
        bus.spi_statusregmicro_i = 8'h22;
        bus.spi_initreq_i        = 1'b1;
        bus.spi_microreq_i       = 1'b1;
        tick(1);
        check("t4_init_first", 64'({bus.spi_initgnt_o, bus.spi_micrognt_o}), 64'h2);
        tick(1);
        cq.push_back('{1'b1, 8'h7E, 1'b0, 1'b0});
        bus.R1            = 8'h7E;
        bus.spi_flagreg_i = 3'b110;
        tick(1);
        check("t4_init_ack", 64'(bus.spi_initack_o), 64'd1);
        bus.spi_initreq_i = 1'b0;
        bus.spi_flagreg_i = 3'b000;
        wait_start(10, n);
        check("t4_micro_spacing", 64'(n), 64'd2);
        tick(1);
        cq.push_back('{1'b0, 8'h22, 1'b0, 1'b0});
        bus.R1            = 8'h22;
        bus.spi_flagreg_i = 3'b010;
        tick(1);
        check("t4_micro_ack", 64'(bus.spi_microack_o), 64'd1);
        bus.spi_microreq_i = 1'b0;
        bus.spi_flagreg_i  = 3'b000;
        tick(2);

        // 5: timeout with master stuck busy
        gq.push_back('{1'b1, 48'h4C0000000001, 8'h5A});
        bus.spi_datainit_i      = 48'h4C0000000001;
        bus.spi_statusreginit_i = 8'h5A;
        bus.spi_flagreg_i       = 3'b001;
        bus.R1                  = 8'h33;
        bus.spi_initreq_i       = 1'b1;
        tick(1);
        check("t5_start", 64'(bus.spi_start_o), 64'd1);
        cq.push_back('{1'b1, 8'hFF, 1'b0, 1'b1});
        n = 0;
        while (!bus.spi_initack_o && n < 40) begin
            tick(1);
            n++;
        end
        check("t5_timeout_latency", 64'(n), 64'd17);
        bus.spi_initreq_i = 1'b0;
        bus.spi_flagreg_i = 3'b000;
        tick(2);
        check("t5_r1_held", 64'({bus.spi_busy_o, bus.spi_r1_o}), 64'h0FF);

        // 6: reset mid-WAIT aborts with no ack, later done is ignored
        gq.push_back('{1'b1, 48'h770000000001, 8'h01});
        bus.spi_datainit_i      = 48'h770000000001;
        bus.spi_statusreginit_i = 8'h01;
        bus.spi_initreq_i       = 1'b1;
        tick(1);
        tick(2);
        check("t6_in_wait", 64'({bus.spi_initgnt_o, bus.spi_busy_o}), 64'h3);
        rst               = 1'b1;
        bus.spi_initreq_i = 1'b0;
        tick(1);
        check_all_zero("t6_reset");
        rst               = 1'b0;
        bus.spi_flagreg_i = 3'b010;
        bus.R1            = 8'h01;
        tick(5);
        check("t6_no_ack", 64'({bus.spi_initack_o, bus.spi_busy_o, bus.spi_r1_o}), 64'd0);
        bus.spi_flagreg_i = 3'b000;
        tick(2);

        check("grant_queue_drained", 64'(gq.size()), 64'd0);
        check("ack_queue_drained", 64'(cq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
